// File: rtl/alu_issue_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl_pkg
// Shared ISA definitions for the ALU issue controller: datapath widths,
// opcode encodings, controller state encoding, the instruction word layout
// and small decode helpers.
// ---------------------------------------------------------------------------
package alu_issue_ctrl_pkg;

    localparam int DATA_W  = 32;  // datapath / register width, equals ALU width
    localparam int REG_AW  = 3;   // register address width (8 registers)
    localparam int OP_W    = 3;   // opcode width, equals ALU op width
    localparam int IMM_W   = 14;  // signed immediate width
    localparam int INSTR_W = 32;

    localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
    localparam logic [OP_W-1:0] OP_MUL  = 3'b001;
    localparam logic [OP_W-1:0] OP_LDR  = 3'b100;
    localparam logic [OP_W-1:0] OP_STR  = 3'b101;
    localparam logic [OP_W-1:0] OP_MOV  = 3'b110;
    localparam logic [OP_W-1:0] OP_DPRO = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MEM  = 2'd2,
        ST_DOT  = 2'd3
    } state_t;

    // Instruction word: [31:29] op, [28:26] rd, [25:23] rs1, [22:20] rs2,
    // [19:14] reserved, [13:0] signed immediate.
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [5:0]        rsvd;
        logic [IMM_W-1:0]  imm;
    } instr_t;

    // Opcodes 010 and 011 are unassigned.
    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return !((op == 3'b010) || (op == 3'b011));
    endfunction

    function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl_if
// Bundles the three buses of the issue controller:
//   instruction handshake : instr_valid, instr, instr_ready
//   ALU drive             : op_code, alu_in1, alu_in2, alu_out
//   memory access         : mem_req, mem_we, mem_addr, mem_wdata,
//                           mem_rdata, mem_ack
// Modports: master = controller side, slave = environment side.
//
// Handshake rules: an instruction transfers on a rising edge where
// instr_valid && instr_ready are both 1; the source keeps instr stable while
// instr_valid=1 and instr_ready=0. mem_req, mem_we, mem_addr and mem_wdata
// stay stable from the first request cycle up to and including the cycle in
// which mem_ack=1; mem_ack is a single-cycle pulse and mem_rdata is only
// meaningful in that cycle.
// ---------------------------------------------------------------------------
interface alu_issue_ctrl_if;
    import alu_issue_ctrl_pkg::*;

    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic               instr_ready;

    logic [OP_W-1:0]    op_code;
    logic [DATA_W-1:0]  alu_in1;
    logic [DATA_W-1:0]  alu_in2;
    logic [DATA_W-1:0]  alu_out;

    logic               mem_req;
    logic               mem_we;
    logic [DATA_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_wdata;
    logic [DATA_W-1:0]  mem_rdata;
    logic               mem_ack;

    modport master (
        input  instr_valid, instr, alu_out, mem_rdata, mem_ack,
        output instr_ready, op_code, alu_in1, alu_in2,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output instr_valid, instr, alu_out, mem_rdata, mem_ack,
        input  instr_ready, op_code, alu_in1, alu_in2,
               mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/alu_issue_ctrl_reg_file.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl_reg_file
// 2**REG_AW x DATA_W register file: one synchronous write port, four
// asynchronous read ports, synchronous active-low clear of every entry.
// Ports:
//   clk, rst_n        clock, synchronous active-low clear
//   we, waddr, wdata  write port (takes effect at the rising edge)
//   ra1..ra4          read addresses
//   rd1..rd4          read data (combinational, pre-write values)
// ---------------------------------------------------------------------------
module alu_issue_ctrl_reg_file #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] ra1,
    input  logic [REG_AW-1:0] ra2,
    input  logic [REG_AW-1:0] ra3,
    input  logic [REG_AW-1:0] ra4,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [DATA_W-1:0] rd3,
    output logic [DATA_W-1:0] rd4
);

    logic [DATA_W-1:0] regs_q [2**REG_AW];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**REG_AW; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign rd1 = regs_q[ra1];
    assign rd2 = regs_q[ra2];
    assign rd3 = regs_q[ra3];
    assign rd4 = regs_q[ra4];

endmodule

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
// Issue controller in front of a combinational ALU. Accepts instruction words,
// reads operands from an 8x32 register file, drives the ALU, sequences
// LDR/STR memory accesses and the multi-cycle DPRO dot product, and writes
// results back.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   bus          instruction / ALU / memory buses (alu_issue_ctrl_if.master)
//   retire       1-cycle pulse when an instruction completes
//   err          1-cycle pulse after an illegal opcode is accepted
//   dbg_addr     debug register select
//   dbg_data     R[dbg_addr], combinational
//   dbg_state    current controller state
// ---------------------------------------------------------------------------
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    alu_issue_ctrl_if.master  bus,
    output logic              retire,
    output logic              err,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output state_t            dbg_state
);

    state_t            state_q, state_d;
    instr_t            ir_q, ir_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [2:0]        k_q, k_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              retire_q, retire_d;
    logic              err_q, err_d;

    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [REG_AW-1:0] ra_rs1, ra_rs2;
    logic [DATA_W-1:0] rs1_data, rs2_data, rd_data;

    instr_t            in_word;
    logic              accept;
    logic              dot_last;
    logic [DATA_W-1:0] dot_sum;
    logic [5:0]        unused_rsvd;

    assign in_word     = instr_t'(bus.instr);
    assign accept      = bus.instr_valid && bus.instr_ready;
    // L = imm[2:0]+1, so the last element is reached when k equals imm[2:0].
    assign dot_last    = (k_q == ir_q.imm[2:0]);
    assign dot_sum     = acc_q + bus.alu_out;
    assign unused_rsvd = ir_q.rsvd;

    // During DOT the element offset k walks both source indices; the 3-bit
    // add wraps them mod 8.
    assign ra_rs1 = (state_q == ST_DOT) ? ir_q.rs1 + k_q : ir_q.rs1;
    assign ra_rs2 = (state_q == ST_DOT) ? ir_q.rs2 + k_q : ir_q.rs2;

    alu_issue_ctrl_reg_file #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_reg_file (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (rf_we),
        .waddr (rf_waddr),
        .wdata (rf_wdata),
        .ra1   (ra_rs1),
        .ra2   (ra_rs2),
        .ra3   (ir_q.rd),
        .ra4   (dbg_addr),
        .rd1   (rs1_data),
        .rd2   (rs2_data),
        .rd3   (rd_data),
        .rd4   (dbg_data)
    );

    // ---- FSM: state register ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- FSM: next state ----
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && op_is_legal(in_word.op)) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if ((ir_q.op == OP_LDR) || (ir_q.op == OP_STR)) begin
                    state_d = ST_MEM;
                end else if (ir_q.op == OP_DPRO) begin
                    state_d = ST_DOT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MEM: begin
                if (bus.mem_ack) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DOT: begin
                if (dot_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---- FSM: outputs (handshake and ALU drive) ----
    always_comb begin
        bus.instr_ready = (state_q == ST_IDLE) && rst_n;
        bus.op_code     = '0;
        bus.alu_in1     = '0;
        bus.alu_in2     = '0;
        case (state_q)
            ST_EXEC: begin
                bus.op_code = ir_q.op;
                bus.alu_in1 = rs1_data;
                // LDR/STR use the ALU as the address adder.
                if ((ir_q.op == OP_LDR) || (ir_q.op == OP_STR)) begin
                    bus.alu_in2 = sext_imm(ir_q.imm);
                end else begin
                    bus.alu_in2 = rs2_data;
                end
            end
            ST_DOT: begin
                bus.op_code = OP_DPRO;
                bus.alu_in1 = rs1_data;
                bus.alu_in2 = rs2_data;
            end
            default: ;
        endcase
    end

    // ---- Datapath next state and register-file write ----
    always_comb begin
        ir_d        = ir_q;
        acc_d       = acc_q;
        k_d         = k_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        retire_d    = 1'b0;
        err_d       = 1'b0;
        rf_we       = 1'b0;
        rf_waddr    = ir_q.rd;
        rf_wdata    = bus.alu_out;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    ir_d  = in_word;
                    err_d = !op_is_legal(in_word.op);
                end
            end
            ST_EXEC: begin
                case (ir_q.op)
                    OP_LDR, OP_STR: begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = (ir_q.op == OP_STR);
                        mem_addr_d  = bus.alu_out;
                        mem_wdata_d = rd_data;
                    end
                    OP_DPRO: begin
                        acc_d = '0;
                        k_d   = '0;
                    end
                    default: begin
                        rf_we    = 1'b1;
                        retire_d = 1'b1;
                    end
                endcase
            end
            ST_MEM: begin
                if (bus.mem_ack) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    retire_d  = 1'b1;
                    rf_we     = (ir_q.op == OP_LDR);
                    rf_wdata  = bus.mem_rdata;
                end
            end
            ST_DOT: begin
                acc_d = dot_sum;
                k_d   = k_q + 3'd1;
                if (dot_last) begin
                    rf_we    = 1'b1;
                    rf_wdata = dot_sum;
                    retire_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ir_q        <= '0;
            acc_q       <= '0;
            k_q         <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            retire_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            ir_q        <= ir_d;
            acc_q       <= acc_d;
            k_q         <= k_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            retire_q    <= retire_d;
            err_q       <= err_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign retire        = retire_q;
    assign err           = err_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        retire;
  logic        err;
  logic [2:0]  dbg_addr;
  logic [31:0] dbg_data;
  state_t      dbg_state;
  int          errors;
  int          checks;

  alu_issue_ctrl_if bus ();

  alu_issue_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.master),
    .retire    (retire),
    .err       (err),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // behavioural ALU in front of the controller
  always_comb begin
    case (bus.op_code)
      3'b000, 3'b100, 3'b101: bus.alu_out = bus.alu_in1 + bus.alu_in2;
      3'b001, 3'b111:         bus.alu_out = bus.alu_in1 * bus.alu_in2;
      3'b110:                 bus.alu_out = bus.alu_in1;
      default:                bus.alu_out = 32'd0;
    endcase
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time exceeded, expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2,
                                      input logic [13:0] imm);
    return {op, rd, rs1, rs2, 6'b0, imm};
  endfunction

  // driver: present one instruction for one edge; call at posedge+1 in IDLE
  task automatic send(input logic [31:0] word);
    bus.instr_valid = 1'b1;
    bus.instr       = word;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    bus.instr       = 32'd0;
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [31:0] d);
    dbg_addr = a;
    #1;
    d = dbg_data;
  endtask

  // driver: load a register through LDR with immediate ack
  task automatic load_reg(input logic [2:0] rd, input logic [31:0] val);
    int n;
    send(enc(OP_LDR, rd, 3'd0, 3'd0, 14'd0));
    n = 0;
    while (!bus.mem_req && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.mem_req) begin
      checks++; errors++;
      $display("FAIL load_reg_timeout: mem_req=0 required 1 after %0d cycles", n);
    end
    bus.mem_rdata = val;
    bus.mem_ack   = 1'b1;
    @(posedge clk); #1;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'd0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_n = 1'b0;
    bus.instr_valid = 1'b0; bus.instr = 32'd0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'd0;
    dbg_addr = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.instr_ready, bus.mem_req, bus.mem_we, retire, err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctl: ready/req/we/retire/err=%b required 00000",
               {bus.instr_ready, bus.mem_req, bus.mem_we, retire, err});
    end
    checks++;
    if ({bus.op_code, bus.alu_in1, bus.alu_in2, bus.mem_addr, bus.mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_bus: op=%0h in1=%0h in2=%0h addr=%0h wdata=%0h required all 0",
               bus.op_code, bus.alu_in1, bus.alu_in2, bus.mem_addr, bus.mem_wdata);
    end
    read_reg(3'd0, d);
    checks++;
    if (d !== 32'd0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state: R0=%0h state=%0d required 0/IDLE", d, dbg_state);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b required 1", bus.instr_ready);
    end
  endtask

  task automatic test_add();
    logic [31:0] d;
    load_reg(3'd1, 32'd5);
    load_reg(3'd2, 32'hFFFF_FFFD);
    send(enc(OP_ADD, 3'd3, 3'd1, 3'd2, 14'd0));
    checks++;
    if (bus.op_code !== 3'b000 || bus.alu_in1 !== 32'd5 || bus.alu_in2 !== 32'hFFFF_FFFD) begin
      errors++;
      $display("FAIL add_exec: op=%0h in1=%0h in2=%0h required 0/5/fffffffd",
               bus.op_code, bus.alu_in1, bus.alu_in2);
    end
    checks++;
    if (retire !== 1'b0 || bus.instr_ready !== 1'b0) begin
      errors++;
      $display("FAIL add_exec_ctl: retire=%b ready=%b required 0/0", retire, bus.instr_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (retire !== 1'b1 || bus.instr_ready !== 1'b1 || bus.op_code !== 3'b000 || bus.alu_in1 !== 32'd0) begin
      errors++;
      $display("FAIL add_retire: retire=%b ready=%b op=%0h in1=%0h required 1/1/0/0",
               retire, bus.instr_ready, bus.op_code, bus.alu_in1);
    end
    read_reg(3'd3, d);
    checks++;
    if (d !== 32'd2) begin
      errors++;
      $display("FAIL add_result: R3=%0h required 2", d);
    end
    @(posedge clk); #1;
    checks++;
    if (retire !== 1'b0) begin
      errors++;
      $display("FAIL add_retire_pulse: retire=%b required 0", retire);
    end
  endtask

  task automatic test_mul_mov();
    logic [31:0] d;
    load_reg(3'd4, 32'hDEAD);
    load_reg(3'd1, 32'h1_0000);
    load_reg(3'd2, 32'h1_0000);
    send(enc(OP_MUL, 3'd4, 3'd1, 3'd2, 14'd0));
    checks++;
    if (bus.op_code !== OP_MUL) begin
      errors++;
      $display("FAIL mul_opcode: got %0h required 1", bus.op_code);
    end
    @(posedge clk); #1;
    read_reg(3'd4, d);
    checks++;
    if (d !== 32'd0 || retire !== 1'b1) begin
      errors++;
      $display("FAIL mul_result: R4=%0h retire=%b required 0/1", d, retire);
    end
    send(enc(OP_MOV, 3'd5, 3'd1, 3'd0, 14'd0));
    checks++;
    if (bus.op_code !== OP_MOV || bus.alu_in1 !== 32'h1_0000) begin
      errors++;
      $display("FAIL mov_exec: op=%0h in1=%0h required 6/10000", bus.op_code, bus.alu_in1);
    end
    @(posedge clk); #1;
    read_reg(3'd5, d);
    checks++;
    if (d !== 32'h1_0000) begin
      errors++;
      $display("FAIL mov_result: R5=%0h required 10000", d);
    end
  endtask

  task automatic test_mem();
    logic [31:0] d;
    // STR R3 (=2) to R0 + 0x40, ack withheld until the third MEM cycle
    send(enc(OP_STR, 3'd3, 3'd0, 3'd0, 14'h40));
    checks++;
    if (bus.op_code !== OP_STR || bus.alu_in2 !== 32'h40 || bus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL str_exec: op=%0h in2=%0h req=%b required 5/40/0",
               bus.op_code, bus.alu_in2, bus.mem_req);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.instr_ready} !==
          {1'b1, 1'b1, 32'h40, 32'd2, 1'b0}) begin
        errors++;
        $display("FAIL str_hold[%0d]: req=%b we=%b addr=%0h wdata=%0h ready=%b required 1/1/40/2/0",
                 i, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.instr_ready);
      end
      if (i == 2) bus.mem_ack = 1'b1;
    end
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    checks++;
    if (bus.mem_req !== 1'b0 || retire !== 1'b1) begin
      errors++;
      $display("FAIL str_done: req=%b retire=%b required 0/1", bus.mem_req, retire);
    end
    // LDR R6 from R1 + (-4), ack in the first MEM cycle
    send(enc(OP_LDR, 3'd6, 3'd1, 3'd0, 14'h3FFC));
    @(posedge clk); #1;
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h0000_FFFC) begin
      errors++;
      $display("FAIL ldr_req: req=%b we=%b addr=%0h required 1/0/fffc",
               bus.mem_req, bus.mem_we, bus.mem_addr);
    end
    bus.mem_rdata = 32'h1234;
    bus.mem_ack   = 1'b1;
    @(posedge clk); #1;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'd0;
    read_reg(3'd6, d);
    checks++;
    if (d !== 32'h1234 || retire !== 1'b1 || bus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL ldr_result: R6=%0h retire=%b req=%b required 1234/1/0", d, retire, bus.mem_req);
    end
  endtask

  task automatic test_dpro();
    logic [31:0] d;
    logic [31:0] e1 [4];
    logic [31:0] e2 [4];
    for (int i = 0; i < 8; i++) load_reg(3'(i), 32'(i + 1));
    // R7 = 1*5 + 2*6 + 3*7 + 4*8 = 70
    send(enc(OP_DPRO, 3'd7, 3'd0, 3'd4, 14'd3));
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.op_code !== OP_DPRO || bus.alu_in1 !== 32'(k + 1) ||
          bus.alu_in2 !== 32'(k + 5) || retire !== 1'b0) begin
        errors++;
        $display("FAIL dot_step[%0d]: op=%0h in1=%0h in2=%0h retire=%b required 7/%0h/%0h/0",
                 k, bus.op_code, bus.alu_in1, bus.alu_in2, retire, k + 1, k + 5);
      end
      @(posedge clk); #1;
    end
    read_reg(3'd7, d);
    checks++;
    if (d !== 32'd70 || retire !== 1'b1 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL dot_result: R7=%0d retire=%b state=%0d required 70/1/IDLE", d, retire, dbg_state);
    end
    // wrap: rs1=6 -> R6,R7,R0,R1 = 7,70,1,2 ; rs2=2 -> 3,4,5,6 ; sum 318
    e1 = '{32'd7, 32'd70, 32'd1, 32'd2};
    e2 = '{32'd3, 32'd4, 32'd5, 32'd6};
    send(enc(OP_DPRO, 3'd0, 3'd6, 3'd2, 14'd3));
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.alu_in1 !== e1[k] || bus.alu_in2 !== e2[k]) begin
        errors++;
        $display("FAIL dot_wrap_step[%0d]: in1=%0d in2=%0d required %0d/%0d",
                 k, bus.alu_in1, bus.alu_in2, e1[k], e2[k]);
      end
      @(posedge clk); #1;
    end
    read_reg(3'd0, d);
    checks++;
    if (d !== 32'd318) begin
      errors++;
      $display("FAIL dot_wrap_result: R0=%0d required 318", d);
    end
    // L=1: R1 = R2*R3 = 12
    send(enc(OP_DPRO, 3'd1, 3'd2, 3'd3, 14'd0));
    @(posedge clk); #1;
    checks++;
    if (retire !== 1'b0 || dbg_state !== ST_DOT) begin
      errors++;
      $display("FAIL dot_l1_mid: retire=%b state=%0d required 0/DOT", retire, dbg_state);
    end
    @(posedge clk); #1;
    read_reg(3'd1, d);
    checks++;
    if (d !== 32'd12 || retire !== 1'b1) begin
      errors++;
      $display("FAIL dot_l1_result: R1=%0d retire=%b required 12/1", d, retire);
    end
    // L=8 self dot product: 318^2+12^2+3^2+4^2+5^2+6^2+7^2+70^2 = 106303
    send(enc(OP_DPRO, 3'd5, 3'd0, 3'd0, 14'd7));
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (retire !== 1'b0 || dbg_state !== ST_DOT) begin
      errors++;
      $display("FAIL dot_l8_mid: retire=%b state=%0d required 0/DOT", retire, dbg_state);
    end
    @(posedge clk); #1;
    read_reg(3'd5, d);
    checks++;
    if (d !== 32'd106303 || retire !== 1'b1) begin
      errors++;
      $display("FAIL dot_l8_result: R5=%0d retire=%b required 106303/1", d, retire);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] d;
    logic [2:0]  ops [2];
    ops = '{3'b010, 3'b011};
    for (int i = 0; i < 2; i++) begin
      send(enc(ops[i], 3'd1, 3'd2, 3'd3, 14'd0));
      checks++;
      if (err !== 1'b1 || retire !== 1'b0 || bus.instr_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
        errors++;
        $display("FAIL illegal_err[%0d]: err=%b retire=%b ready=%b state=%0d required 1/0/1/IDLE",
                 i, err, retire, bus.instr_ready, dbg_state);
      end
      @(posedge clk); #1;
      read_reg(3'd1, d);
      checks++;
      if (err !== 1'b0 || d !== 32'd12) begin
        errors++;
        $display("FAIL illegal_after[%0d]: err=%b R1=%0d required 0/12", i, err, d);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    // R2 = R3+R4 = 4+5 = 9 ; then R3 = R2+R2 = 18 using the new R2
    bus.instr_valid = 1'b1;
    bus.instr = enc(OP_ADD, 3'd2, 3'd3, 3'd4, 14'd0);
    @(posedge clk); #1;
    checks++;
    if (bus.instr_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_exec_ready: ready=%b required 0", bus.instr_ready);
    end
    bus.instr = enc(OP_ADD, 3'd3, 3'd2, 3'd2, 14'd0);
    @(posedge clk); #1;
    checks++;
    if (bus.instr_ready !== 1'b1 || retire !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle: ready=%b retire=%b required 1/1", bus.instr_ready, retire);
    end
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    bus.instr = 32'd0;
    checks++;
    if (bus.alu_in1 !== 32'd9 || bus.alu_in2 !== 32'd9 || dbg_state !== ST_EXEC) begin
      errors++;
      $display("FAIL b2b_second_exec: in1=%0d in2=%0d state=%0d required 9/9/EXEC",
               bus.alu_in1, bus.alu_in2, dbg_state);
    end
    @(posedge clk); #1;
    read_reg(3'd3, d);
    checks++;
    if (d !== 32'd18 || retire !== 1'b1) begin
      errors++;
      $display("FAIL b2b_result: R3=%0d retire=%b required 18/1", d, retire);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    send(enc(OP_STR, 3'd1, 3'd0, 3'd0, 14'h10));
    @(posedge clk); #1;
    checks++;
    if (bus.mem_req !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_req: req=%b required 1", bus.mem_req);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0 || bus.instr_ready !== 1'b0 || retire !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_drop: req=%b we=%b ready=%b retire=%b required 0/0/0/0",
               bus.mem_req, bus.mem_we, bus.instr_ready, retire);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.instr_ready !== 1'b1 || dbg_state !== ST_IDLE || bus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_release: ready=%b state=%0d req=%b required 1/IDLE/0",
               bus.instr_ready, dbg_state, bus.mem_req);
    end
    for (int i = 0; i < 8; i++) begin
      read_reg(3'(i), d);
      checks++;
      if (d !== 32'd0) begin
        errors++;
        $display("FAIL rstmid_reg[%0d]: got %0h required 0", i, d);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_add();
    test_mul_mov();
    test_mem();
    test_dpro();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
